// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and the
// parity helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Returns the parity bit a correct frame carries for the given data word.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX input synchroniser and falling-edge detector; every stage idles high so
// leaving reset never looks like a start edge.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_prev & ~rxs;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: glitch-filtered start detection, optional parity,
// stop-bit checking, overrun flag and the sticky rdy/clr_rdy handshake.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned BAUD_DIV    = 100,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          PAR_SEL   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_t              state;
    logic [BW-1:0]          baud_cnt;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   perr;
    logic                   rxs;
    logic                   fall;
    logic                   mid_bit;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .rx  (RX),
        .rxs (rxs),
        .fall(fall)
    );

    assign mid_bit = (baud_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            perr       <= 1'b0;
            rx_data    <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (clr_rdy && rdy) begin
                rdy        <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        perr     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (mid_bit) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (mid_bit) begin
                        baud_cnt <= '0;
                        perr     <= (rxs != calc_parity(MAX_DATA_BITS'(shift_reg), PAR_SEL));
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Completion is written after the clear above so it wins a same-cycle clr_rdy.
                    if (mid_bit) begin
                        baud_cnt   <= '0;
                        rx_data    <= shift_reg;
                        rdy        <= 1'b1;
                        parity_err <= perr;
                        frame_err  <= ~rxs;
                        overrun    <= ~clr_rdy & (overrun | rdy);
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: 8N1, 8E1 and 5N1 instances at BAUD_DIV=16.
module tb_uart_rx_param;

    localparam int BAUD = 16;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst, clr_rdy;
    logic rx0, rx1, rx2;

    logic       rdy0, perr0, ferr0, ovr0, busy0;
    logic [7:0] data0;
    logic       rdy1, perr1, ferr1, ovr1, busy1;
    logic [7:0] data1;
    logic       rdy2, perr2, ferr2, ovr2, busy2;
    logic [4:0] data2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(SYNC)) u_8n1 (
        .clk(clk), .rst(rst), .RX(rx0), .clr_rdy(clr_rdy), .rdy(rdy0), .rx_data(data0),
        .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0));

    uart_rx_param #(.DATA_BITS(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(SYNC)) u_8e1 (
        .clk(clk), .rst(rst), .RX(rx1), .clr_rdy(clr_rdy), .rdy(rdy1), .rx_data(data1),
        .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1));

    uart_rx_param #(.DATA_BITS(5), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(SYNC)) u_5n1 (
        .clk(clk), .rst(rst), .RX(rx2), .clr_rdy(clr_rdy), .rdy(rdy2), .rx_data(data2),
        .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2), .busy(busy2));

    // Outputs of the instance currently under test
    int         sel = 0;
    logic       m_rdy, m_perr, m_ferr, m_ovr, m_busy;
    logic [8:0] m_data;

    always_comb begin
        m_rdy  = rdy0;  m_perr = perr0; m_ferr = ferr0; m_ovr = ovr0; m_busy = busy0;
        m_data = {1'b0, data0};
        case (sel)
            1: begin
                m_rdy  = rdy1;  m_perr = perr1; m_ferr = ferr1; m_ovr = ovr1; m_busy = busy1;
                m_data = {1'b0, data1};
            end
            2: begin
                m_rdy  = rdy2;  m_perr = perr2; m_ferr = ferr2; m_ovr = ovr2; m_busy = busy2;
                m_data = {4'b0, data2};
            end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected completion pushed when a frame's start bit is driven
    typedef struct {
        int         due;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
        logic       busy;
        logic       rdy_before;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic rdy_q = 1'b0;

    initial forever begin
        @(negedge clk);
        if (sb.size() != 0 && cyc >= sb[0].due) begin
            mon_e = sb.pop_front();
            check("mon_rdy",      32'(m_rdy),  1);
            check("mon_rdy_prev", 32'(rdy_q),  32'(mon_e.rdy_before));
            check("mon_data",     32'(m_data), 32'(mon_e.data));
            check("mon_perr",     32'(m_perr), 32'(mon_e.perr));
            check("mon_ferr",     32'(m_ferr), 32'(mon_e.ferr));
            check("mon_ovr",      32'(m_ovr),  32'(mon_e.ovr));
            check("mon_busy",     32'(m_busy), 32'(mon_e.busy));
        end
        rdy_q = m_rdy;
    end

    int clr_at = -1;

    task automatic tick();
        @(negedge clk);
        clr_rdy = (cyc == clr_at);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        tick();
    endtask

    task automatic set_rx(input int s, input logic v);
        case (s)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    function automatic int nbits(input int s);
        return (s == 2) ? 5 : 8;
    endfunction

    function automatic int npar(input int s);
        return (s == 1) ? 1 : 0;
    endfunction

    // Cycles from driving the start bit to rdy being visible: synchroniser + frame latency
    function automatic int lat(input int s);
        return SYNC + BAUD / 2 + (nbits(s) + npar(s) + 1) * BAUD + 1;
    endfunction

    task automatic push(input int s, input logic [8:0] d, input logic pe, input logic fe,
                        input logic ov, input logic bz, input logic rb);
        exp_t e;
        e.due = cyc + lat(s); e.data = d; e.perr = pe; e.ferr = fe;
        e.ovr = ov; e.busy = bz; e.rdy_before = rb;
        sb.push_back(e);
    endtask

    task automatic send(input int s, input logic [8:0] d, input logic pb, input logic stop_bit);
        set_rx(s, 1'b0);
        repeat (BAUD) tick();
        for (int b = 0; b < nbits(s); b++) begin
            set_rx(s, d[b]);
            repeat (BAUD) tick();
        end
        if (npar(s) != 0) begin
            set_rx(s, pb);
            repeat (BAUD) tick();
        end
        set_rx(s, stop_bit);
        repeat (BAUD) tick();
    endtask

    task automatic wait_drain(input int limit);
        for (int k = 0; k < limit && sb.size() != 0; k++) tick();
        check("sb_drain", 32'(sb.size()), 0);
        sb.delete();
    endtask

    typedef struct {
        int         s;
        logic [8:0] data;
        logic       par_bit;
        logic       stop_bit;
        int         hold_low;
        logic       do_clr;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[9];
    vec_t v;
    int   due2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1);
    end

    initial begin
        //             s  data     par   stop  hold do_clr exp_data perr  ferr  busy
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 0,  1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h000, 1'b0, 1'b1, 0,  1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h0FF, 1'b0, 1'b1, 0,  1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1, 9'h003, 1'b1, 1'b1, 0,  1'b1, 9'h003, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h003, 1'b0, 1'b1, 0,  1'b1, 9'h003, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h080, 1'b1, 1'b1, 0,  1'b1, 9'h080, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h07F, 1'b0, 1'b1, 0,  1'b1, 9'h07F, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{0, 9'h055, 1'b0, 1'b0, 40, 1'b1, 9'h055, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{2, 9'h015, 1'b0, 1'b1, 0,  1'b0, 9'h015, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; clr_rdy = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_flags", 32'({m_rdy, m_perr, m_ferr, m_ovr, m_busy}), 0);
            check("rst_data",  32'(m_data), 0);
        end
        rst = 1'b0;
        sel = 0;
        repeat (5) tick();

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            sel = v.s;
            tick();
            push(v.s, v.exp_data, v.exp_perr, v.exp_ferr, 1'b0, v.exp_busy, 1'b0);
            send(v.s, v.data, v.par_bit, v.stop_bit);
            wait_drain(60);
            if (v.stop_bit == 1'b0) begin
                pulse_clr();
                repeat (v.hold_low) tick();
                check("break_rdy",  32'(m_rdy),  0);
                check("break_busy", 32'(m_busy), 1);
                set_rx(v.s, 1'b1);
                repeat (SYNC + 3) tick();
                check("break_exit_busy", 32'(m_busy), 0);
                repeat (200) tick();
                check("break_no_frame", 32'(m_rdy), 0);
            end else if (v.do_clr) begin
                pulse_clr();
                check("clr_flags", 32'({m_rdy, m_perr, m_ferr, m_ovr}), 0);
            end
            repeat (10) tick();
        end

        // Reset in the middle of data bit 3 of a 5N1 frame, with a previous frame still pending
        sel = 2;
        tick();
        check("pre_rst_rdy", 32'(m_rdy), 1);
        rx2 = 1'b0;
        repeat (BAUD) tick();
        for (int b = 0; b < 3; b++) begin
            rx2 = 1'b1;
            repeat (BAUD) tick();
        end
        repeat (BAUD / 2) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_flags", 32'({m_rdy, m_perr, m_ferr, m_ovr, m_busy}), 0);
        check("rst_mid_data",  32'(m_data), 0);
        rst = 1'b0;
        repeat (120) tick();
        check("rst_mid_no_rdy", 32'({m_rdy, m_busy}), 0);
        push(2, 9'h00A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2, 9'h00A, 1'b0, 1'b1);
        wait_drain(60);
        pulse_clr();
        repeat (10) tick();

        // Start-bit glitch shorter than half a bit
        sel = 0;
        tick();
        rx0 = 1'b0;
        repeat (5) tick();
        check("glitch_busy_hi", 32'(m_busy), 1);
        rx0 = 1'b1;
        repeat (30) tick();
        check("glitch_busy_lo", 32'(m_busy), 0);
        repeat (170) tick();
        check("glitch_flags", 32'({m_rdy, m_perr, m_ferr, m_ovr, m_busy}), 0);

        // Back-to-back frames without clr_rdy: overrun
        push(0, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(0, 9'h011, 1'b0, 1'b1);
        push(0, 9'h022, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(0, 9'h022, 1'b0, 1'b1);
        wait_drain(60);
        pulse_clr();
        check("ovr_clr", 32'({m_rdy, m_ovr}), 0);
        repeat (10) tick();

        // clr_rdy coinciding with the second completion: completion wins, no overrun
        push(0, 9'h033, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(0, 9'h033, 1'b0, 1'b1);
        due2   = cyc + lat(0);
        clr_at = due2 - 1;
        push(0, 9'h044, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(0, 9'h044, 1'b0, 1'b1);
        clr_at = -1;
        wait_drain(60);
        pulse_clr();
        check("coinc_clr", 32'({m_rdy, m_ovr}), 0);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
